// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MD_BUSY  = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF         = 2'b00;
  localparam logic [1:0] FWD_W          = 2'b01;
  localparam logic [1:0] FWD_M          = 2'b10;
  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  // x0 is hard-wired to zero, so a write to it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Forwarding select for one Execute operand; Memory stage wins over Writeback.
module hazard_fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] fwd_sel
);

  always_comb begin
    // NOTE: default assigned first so every path drives fwd_sel and no latch is inferred.
    fwd_sel = FWD_RF;
    if (reg_write_m && reg_match(rd_m, rs_e)) begin
      fwd_sel = FWD_M;
    end else if (reg_write_w && reg_match(rd_w, rs_e)) begin
      fwd_sel = FWD_W;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: forwarding, stalls, flushes, mul/div and memory waits.
// Define HAZARD_PERF_CNT_EN to add the o_StallCycles / o_FlushCount performance counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULDIV_LATENCY = 4,
  parameter int MEM_TIMEOUT    = 255,
  parameter int CNT_W          = 8
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic [4:0]  i_Rs1D,
  input  logic [4:0]  i_Rs2D,
  input  logic [4:0]  i_Rs1E,
  input  logic [4:0]  i_Rs2E,
  input  logic [4:0]  i_RdE,
  input  logic [1:0]  i_ResultSrcE,
  input  logic        i_PCSrcE,
  input  logic        i_MulDivStartE,
  input  logic [4:0]  i_RdM,
  input  logic [4:0]  i_RdW,
  input  logic        i_RegWriteM,
  input  logic        i_RegWriteW,
  input  logic        i_MemReqM,
  input  logic        i_DMemReady,
  output logic [1:0]  o_ForwardAE,
  output logic [1:0]  o_ForwardBE,
  output logic        o_StallF,
  output logic        o_StallD,
  output logic        o_StallE,
  output logic        o_StallM,
  output logic        o_FlushD,
  output logic        o_FlushE,
  output logic        o_FlushM,
  output logic        o_FlushW,
  output logic        o_MulDivDoneE,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] o_StallCycles,
  output logic [31:0] o_FlushCount,
`endif
  output logic        o_MemTimeout
);

  // The start cycle is the first of MULDIV_LATENCY cycles in E, so MD_BUSY counts the rest down to 0.
  localparam logic [CNT_W-1:0] MD_LOAD =
    (MULDIV_LATENCY > 1) ? CNT_W'(MULDIV_LATENCY - 2) : CNT_W'(0);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
  localparam bit               MD_SINGLE   = (MULDIV_LATENCY == 1);

  hz_state_e        state, state_n;
  logic             ret_md, ret_md_n;
  logic [CNT_W-1:0] md_cnt, md_cnt_n;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
  logic             mem_wait, md_active, md_stall, lw_stall, timeout_set;

  hazard_fwd_unit u_fwd_a (
    .rs_e(i_Rs1E), .rd_m(i_RdM), .rd_w(i_RdW),
    .reg_write_m(i_RegWriteM), .reg_write_w(i_RegWriteW), .fwd_sel(o_ForwardAE)
  );

  hazard_fwd_unit u_fwd_b (
    .rs_e(i_Rs2E), .rd_m(i_RdM), .rd_w(i_RdW),
    .reg_write_m(i_RegWriteM), .reg_write_w(i_RegWriteW), .fwd_sel(o_ForwardBE)
  );

  assign mem_wait  = i_MemReqM && !i_DMemReady;
  assign md_active = (state == MD_BUSY) || ((state == MEM_WAIT) && ret_md);
  assign lw_stall  = (i_ResultSrcE == RESULTSRC_LOAD) &&
                     (reg_match(i_RdE, i_Rs1D) || reg_match(i_RdE, i_Rs2D));

  // A memory wait freezes the whole sequencer; the mul/div context is parked in ret_md.
  always_comb begin
    state_n       = state;
    ret_md_n      = 1'b0;
    md_cnt_n      = md_cnt;
    wait_cnt_n    = '0;
    md_stall      = 1'b0;
    o_MulDivDoneE = 1'b0;
    if (mem_wait) begin
      state_n    = MEM_WAIT;
      ret_md_n   = md_active;
      wait_cnt_n = (wait_cnt == TIMEOUT_CNT) ? wait_cnt : wait_cnt + 1'b1;
    end else if (md_active) begin
      if (md_cnt == '0) begin
        o_MulDivDoneE = 1'b1;
        state_n       = IDLE;
      end else begin
        md_stall = 1'b1;
        md_cnt_n = md_cnt - 1'b1;
        state_n  = MD_BUSY;
      end
    end else begin
      state_n = IDLE;
      if (i_MulDivStartE) begin
        if (MD_SINGLE) begin
          o_MulDivDoneE = 1'b1;
        end else begin
          md_stall = 1'b1;
          md_cnt_n = MD_LOAD;
          state_n  = MD_BUSY;
        end
      end
    end
  end

  assign timeout_set = mem_wait && (wait_cnt_n == TIMEOUT_CNT);

  // Priority chain: a stalled stage is never flushed by a lower-priority hazard.
  always_comb begin
    {o_StallF, o_StallD, o_StallE, o_StallM} = '0;
    {o_FlushD, o_FlushE, o_FlushM, o_FlushW} = '0;
    if (mem_wait) begin
      {o_StallF, o_StallD, o_StallE, o_StallM} = '1;
      o_FlushW = 1'b1;
    end else if (md_stall) begin
      {o_StallF, o_StallD, o_StallE} = '1;
      o_FlushM = 1'b1;
    end else if (i_PCSrcE) begin
      o_FlushD = 1'b1;
      o_FlushE = 1'b1;
    end else if (lw_stall) begin
      o_StallF = 1'b1;
      o_StallD = 1'b1;
      o_FlushE = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      state        <= IDLE;
      ret_md       <= 1'b0;
      md_cnt       <= '0;
      wait_cnt     <= '0;
      o_MemTimeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= state_n;
      ret_md   <= ret_md_n;
      md_cnt   <= md_cnt_n;
      wait_cnt <= wait_cnt_n;
      if (timeout_set) begin
        o_MemTimeout <= 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      o_StallCycles <= '0;
      o_FlushCount  <= '0;
    end else begin
      if (o_StallF) begin
        o_StallCycles <= o_StallCycles + 32'd1;
      end
      if (i_PCSrcE && !mem_wait && !md_stall) begin
        o_FlushCount <= o_FlushCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed literal cases plus randomized traffic against a cycle model.
module tb_pipeline_hazard_ctrl;

  localparam int L   = 4;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0] result_src_e;
  logic       pc_src_e, md_start_e, reg_write_m, reg_write_w, mem_req_m, dmem_ready;
  logic [1:0] fwd_a, fwd_b;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_m, flush_w;
  logic       md_done, mem_timeout;
  logic [7:0] ctl;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
  logic [31:0] m_stall_cycles = '0, m_flush_count = '0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: cycles the current mul/div op has spent in E, consecutive wait cycles, sticky timeout.
  int md_age   = 0;
  int wait_run = 0;
  bit tmo      = 1'b0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MULDIV_LATENCY(L), .MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
    .i_Clk(clk), .i_Reset(rst_n),
    .i_Rs1D(rs1_d), .i_Rs2D(rs2_d), .i_Rs1E(rs1_e), .i_Rs2E(rs2_e), .i_RdE(rd_e),
    .i_ResultSrcE(result_src_e), .i_PCSrcE(pc_src_e), .i_MulDivStartE(md_start_e),
    .i_RdM(rd_m), .i_RdW(rd_w), .i_RegWriteM(reg_write_m), .i_RegWriteW(reg_write_w),
    .i_MemReqM(mem_req_m), .i_DMemReady(dmem_ready),
    .o_ForwardAE(fwd_a), .o_ForwardBE(fwd_b),
    .o_StallF(stall_f), .o_StallD(stall_d), .o_StallE(stall_e), .o_StallM(stall_m),
    .o_FlushD(flush_d), .o_FlushE(flush_e), .o_FlushM(flush_m), .o_FlushW(flush_w),
    .o_MulDivDoneE(md_done),
`ifdef HAZARD_PERF_CNT_EN
    .o_StallCycles(stall_cycles), .o_FlushCount(flush_count),
`endif
    .o_MemTimeout(mem_timeout)
  );

  assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
    if (reg_write_m && rd_m != 5'd0 && rd_m == rs) return 2'b10;
    if (reg_write_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle_in();
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    result_src_e = 2'b00;
    {pc_src_e, md_start_e, reg_write_m, reg_write_w, mem_req_m, dmem_ready} = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model, evaluated mid-cycle; model state then advances to its post-edge value.
  always @(negedge clk) begin : compare
    bit mem, hi, lw, mdst, done;
    int age;
    logic [7:0] exp_ctl;
    if (!rst_n) begin
      md_age = 0; wait_run = 0; tmo = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
      m_stall_cycles = '0; m_flush_count = '0;
`endif
    end
    mem = mem_req_m && !dmem_ready;
    age = 0; mdst = 1'b0; done = 1'b0;
    if (!mem && (md_age > 0 || md_start_e)) begin
      age = md_age + 1;
      if (age >= L) done = 1'b1;
      else          mdst = 1'b1;
    end
    hi = mem || mdst;
    lw = (result_src_e == 2'b01) && rd_e != 5'd0 && (rd_e == rs1_d || rd_e == rs2_d);
    exp_ctl = {hi || (!pc_src_e && lw), hi || (!pc_src_e && lw), hi, mem,
               !hi && pc_src_e, !hi && (pc_src_e || lw), !mem && mdst, mem};
    check("model_ctl", ctl, exp_ctl);
    check("model_fwd_a", fwd_a, fwd_exp(rs1_e));
    check("model_fwd_b", fwd_b, fwd_exp(rs2_e));
    check("model_done", md_done, done);
    check("model_timeout", mem_timeout, tmo);
`ifdef HAZARD_PERF_CNT_EN
    check("model_stall_cycles", stall_cycles, m_stall_cycles);
    check("model_flush_count", flush_count, m_flush_count);
`endif
    if (rst_n) begin
      if (!mem) md_age = done ? 0 : age;
      if (mem) begin
        wait_run++;
        if (wait_run >= TMO) tmo = 1'b1;
      end else begin
        wait_run = 0;
      end
`ifdef HAZARD_PERF_CNT_EN
      m_stall_cycles += 32'(exp_ctl[7]);
      m_flush_count  += 32'(!hi && pc_src_e);
`endif
    end
  end

  initial begin
    logic [3:0] md_stall_pat;
    logic [6:0] md_done_pat;
    idle_in();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_timeout", mem_timeout, 1'b0);
    check("rst_done", md_done, 1'b0);
    check("rst_ctl", ctl, 8'h00);
    next_cycle();
    rst_n = 1'b1;

    // Forwarding: M over W, then W, then x0 never forwarded.
    reg_write_m = 1'b1; rd_m = 5'd5; rs1_e = 5'd5; rs2_e = 5'd5;
    reg_write_w = 1'b1; rd_w = 5'd5;
    @(negedge clk);
    check("fwd_a_m", fwd_a, 2'b10);
    check("fwd_b_m", fwd_b, 2'b10);
    next_cycle(); rd_m = 5'd0;
    @(negedge clk);
    check("fwd_a_w", fwd_a, 2'b01);
    next_cycle(); rd_w = 5'd0;
    @(negedge clk);
    check("fwd_a_x0", fwd_a, 2'b00);

    // Load-use, then load-use together with a taken branch.
    next_cycle(); idle_in(); result_src_e = 2'b01; rd_e = 5'd7; rs2_d = 5'd7;
    @(negedge clk);
    check("lw_ctl", ctl, 8'b1100_0100);
    next_cycle(); pc_src_e = 1'b1;
    @(negedge clk);
    check("lw_branch_ctl", ctl, 8'b0000_1100);
    next_cycle(); idle_in();
    @(negedge clk);
    check("lw_released", ctl, 8'h00);

    // Mul/div: three stall cycles, done on the fourth.
    md_stall_pat = 4'b0111;
    next_cycle(); md_start_e = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("md_ctl", ctl, md_stall_pat[i] ? 8'b1110_0010 : 8'h00);
      check("md_done", md_done, !md_stall_pat[i]);
      next_cycle();
    end
    md_start_e = 1'b0;
    @(negedge clk);
    check("md_after_done", md_done, 1'b0);

    // Memory wait of three cycles, then release on ready.
    next_cycle(); mem_req_m = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mem_wait_ctl", ctl, 8'b1111_0001);
      next_cycle();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    check("mem_release_ctl", ctl, 8'h00);

    // Timeout after eight consecutive waits; sticky until reset.
    next_cycle(); dmem_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check("tmo_rise", mem_timeout, i > TMO);
      next_cycle();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    check("tmo_sticky_ready", mem_timeout, 1'b1);
    next_cycle(); mem_req_m = 1'b0;
    @(negedge clk);
    check("tmo_sticky_idle", mem_timeout, 1'b1);
    next_cycle(); rst_n = 1'b0;
    #1;
    check("tmo_cleared_by_reset", mem_timeout, 1'b0);
    next_cycle(); rst_n = 1'b1;

    // Memory wait in the second mul/div cycle delays done by the wait length.
    md_done_pat = 7'b100_0000;
    next_cycle(); md_start_e = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("md_mem_done", md_done, md_done_pat[i]);
      if (i >= 1 && i <= 3) check("md_mem_ctl", ctl, 8'b1111_0001);
      next_cycle();
      if (i == 0) begin mem_req_m = 1'b1; dmem_ready = 1'b0; end
      if (i == 3) dmem_ready = 1'b1;
      if (i == 4) begin mem_req_m = 1'b0; dmem_ready = 1'b0; end
    end
    md_start_e = 1'b0;

    // Reset in the middle of MD_BUSY aborts with no done pulse.
    next_cycle(); md_start_e = 1'b1;
    repeat (2) @(negedge clk);
    check("md_busy_before_rst", stall_e, 1'b1);
    next_cycle(); rst_n = 1'b0; md_start_e = 1'b0;
    #1;
    check("md_rst_ctl", ctl, 8'h00);
    check("md_rst_done", md_done, 1'b0);
    repeat (2) next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("md_rst_no_done", md_done, 1'b0);
    end

    // Randomized traffic, checked by the model process every cycle.
    for (int c = 0; c < 2000; c++) begin
      next_cycle();
      rst_n        = ($urandom_range(0, 249) != 0);
      rs1_d        = 5'($urandom_range(0, 7));
      rs2_d        = 5'($urandom_range(0, 7));
      rs1_e        = 5'($urandom_range(0, 7));
      rs2_e        = 5'($urandom_range(0, 7));
      rd_e         = 5'($urandom_range(0, 7));
      rd_m         = 5'($urandom_range(0, 7));
      rd_w         = 5'($urandom_range(0, 7));
      result_src_e = 2'($urandom_range(0, 3));
      reg_write_m  = ($urandom_range(0, 9) < 7);
      reg_write_w  = ($urandom_range(0, 9) < 7);
      pc_src_e     = ($urandom_range(0, 99) < 15);
      md_start_e   = ($urandom_range(0, 99) < 20);
      mem_req_m    = ($urandom_range(0, 99) < 35);
      dmem_ready   = ($urandom_range(0, 99) < ((c % 400) < 50 ? 5 : 55));
    end

    next_cycle();
    idle_in();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
